// File: rtl/edge_event_arb_pkg.sv
// Shared types and helpers for the edge-event arbiter.
// EDGE_ARB_FIXED_PRIO_EN (optional) selects fixed-priority grant order in the arbiter.
package edge_arb_pkg;

  localparam int unsigned MAX_CH = 16;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  // Channel index width, never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/edge_event_arb_if.sv
// Event handshake between the arbiter (master) and the downstream consumer (slave).
interface edge_event_arb_if #(
  parameter int unsigned IDX_W = 2
);

  logic             ev_valid;
  logic [IDX_W-1:0] ev_ch;
  logic             ev_ready;

  modport master (output ev_valid, output ev_ch, input ev_ready);
  modport slave  (input ev_valid, input ev_ch, output ev_ready);

endinterface

// File: rtl/edge_event_arb_rr_pick.sv
// Combinational channel picker: round-robin after 'last', or lowest index when
// EDGE_ARB_FIXED_PRIO_EN is defined.
module rr_pick #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned IDX_W  = 2
) (
  input  logic [NUM_CH-1:0] elig,
  input  logic [IDX_W-1:0]  last,
  output logic              found,
  output logic [IDX_W-1:0]  idx
);

`ifdef EDGE_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!found && elig[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end
`else
  int unsigned      pos;
  logic [IDX_W-1:0] sel;

  // Visit last+1 .. last+NUM_CH modulo NUM_CH; 'last' itself is checked last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    sel   = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      pos = (32'(last) + k) % NUM_CH;
      sel = IDX_W'(pos);
      if (!found && elig[sel]) begin
        found = 1'b1;
        idx   = sel;
      end
    end
  end
`endif

endmodule

// File: rtl/edge_event_arb.sv
// Per-channel saturating edge counters feeding one valid/ready event port.
// EDGE_ARB_FIXED_PRIO_EN defined: lowest-index grant, no last_grant register.
module edge_event_arb
  import edge_arb_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] edge_in,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              clr_ovf,
  output logic              pend_any,
  output logic [NUM_CH-1:0] ovf,
  edge_event_arb_if.master  ev
);

  localparam int unsigned      IDX_W   = idx_w(NUM_CH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [0:0]       S_EMPTY = EMPTY;
  localparam logic [0:0]       S_FULL  = FULL;

  logic [0:0]                   state, state_nxt;
  logic [IDX_W-1:0]             ch_q, ch_nxt;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt, cnt_nxt;
  logic [NUM_CH-1:0]            ovf_nxt, elig, inc, grant;
  logic [IDX_W-1:0]             pick, last_sel;
  logic                         load, found;

  assign ev.ev_valid = (state == S_FULL);
  assign ev.ev_ch    = ch_q;
  assign load        = (state == S_EMPTY) || ev.ev_ready;
  assign inc         = edge_in & ch_en;

  always_comb begin
    pend_any = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      elig[i]  = (cnt[i] != '0) && ch_en[i];
      grant[i] = load && found && (pick == IDX_W'(i));
      pend_any = pend_any || (cnt[i] != '0);
    end
  end

  rr_pick #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_pick (
    .elig  (elig),
    .last  (last_sel),
    .found (found),
    .idx   (pick)
  );

`ifdef EDGE_ARB_FIXED_PRIO_EN
  assign last_sel = '0;
`else
  logic [IDX_W-1:0] last_q;
  assign last_sel = last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                last_q <= IDX_W'(NUM_CH - 1);
    else if (load && found) last_q <= pick;
  end
`endif

  // Output stage: load a new grant whenever the slot is empty or being accepted.
  always_comb begin
    state_nxt = state;
    ch_nxt    = ch_q;
    if (load) begin
      if (found) begin
        state_nxt = S_FULL;
        ch_nxt    = pick;
      end else begin
        state_nxt = S_EMPTY;
      end
    end
  end

  // Counters saturate at CNT_MAX; a set on overflow beats a same-cycle clear.
  always_comb begin
    cnt_nxt = cnt;
    ovf_nxt = clr_ovf ? '0 : ovf;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (inc[i] && !grant[i]) begin
        if (cnt[i] == CNT_MAX) ovf_nxt[i] = 1'b1;
        else                   cnt_nxt[i] = cnt[i] + CNT_W'(1);
      end else if (!inc[i] && grant[i]) begin
        cnt_nxt[i] = cnt[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_EMPTY;
      ch_q  <= '0;
      cnt   <= '0;
      ovf   <= '0;
    end else begin
      state <= state_nxt;
      ch_q  <= ch_nxt;
      cnt   <= cnt_nxt;
      ovf   <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_edge_event_arb.sv
// Directed bench for edge_event_arb with a per-cycle reference model and literal checks.
module tb_edge_event_arb;

  localparam int NCH  = 4;
  localparam int CMAX = 7;

  logic           clk;
  logic           rst;
  logic [NCH-1:0] edge_in;
  logic [NCH-1:0] ch_en;
  logic           clr_ovf;
  logic           pend_any;
  logic [NCH-1:0] ovf;

  edge_event_arb_if #(.IDX_W(2)) ev ();

  edge_event_arb #(.NUM_CH(NCH), .CNT_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .edge_in  (edge_in),
    .ch_en    (ch_en),
    .clr_ovf  (clr_ovf),
    .pend_any (pend_any),
    .ovf      (ovf),
    .ev       (ev)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int acc [NCH];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: pending counts, presented slot, and last granted channel.
  int       m_cnt [NCH];
  bit [3:0] m_ovf;
  bit       m_valid;
  int       m_ch;
  int       m_last;

  always @(posedge clk or posedge rst) begin
    bit       load;
    int       gnt, j, n;
    bit [3:0] set;
    if (rst) begin
      for (int i = 0; i < NCH; i++) m_cnt[i] <= 0;
      m_ovf   <= '0;
      m_valid <= 1'b0;
      m_ch    <= 0;
      m_last  <= NCH - 1;
    end else begin
      load = !m_valid || ev.ev_ready;
      gnt  = -1;
      set  = '0;
      if (load) begin
        for (int k = 0; k < NCH; k++) begin
`ifdef EDGE_ARB_FIXED_PRIO_EN
          j = k;
`else
          j = (m_last + 1 + k) % NCH;
`endif
          if (gnt < 0 && m_cnt[j] > 0 && ch_en[j]) gnt = j;
        end
      end
      for (int i = 0; i < NCH; i++) begin
        n = m_cnt[i] + ((edge_in[i] && ch_en[i]) ? 1 : 0) - ((gnt == i) ? 1 : 0);
        if (n > CMAX) begin
          n      = CMAX;
          set[i] = 1'b1;
        end
        m_cnt[i] <= n;
      end
      m_ovf <= (clr_ovf ? 4'b0000 : m_ovf) | set;
      if (load) begin
        m_valid <= (gnt >= 0);
        if (gnt >= 0) begin
          m_ch   <= gnt;
          m_last <= gnt;
        end
      end
    end
  end

  function automatic int m_pend();
    int p = 0;
    for (int i = 0; i < NCH; i++) if (m_cnt[i] > 0) p = 1;
    return p;
  endfunction

  // Cycle-by-cycle comparison against the model, plus per-channel acceptance tally.
  always @(negedge clk) begin
    if (!rst) begin
      chk("mon_valid", int'(ev.ev_valid), int'(m_valid));
      chk("mon_ch", int'(ev.ev_ch), m_ch);
      chk("mon_pend", int'(pend_any), m_pend());
      chk("mon_ovf", int'(ovf), int'(m_ovf));
      if (ev.ev_valid && ev.ev_ready) acc[ev.ev_ch]++;
    end
  end

  initial begin
    rst         = 1'b1;
    edge_in     = '0;
    ch_en       = 4'b1111;
    clr_ovf     = 1'b0;
    ev.ev_ready = 1'b0;
    for (int i = 0; i < NCH; i++) acc[i] = 0;

    #1;
    chk("rst_valid", int'(ev.ev_valid), 0);
    chk("rst_ch", int'(ev.ev_ch), 0);
    chk("rst_pend", int'(pend_any), 0);
    chk("rst_ovf", int'(ovf), 0);
    step();
    step();
    rst = 1'b0;

    // Round-robin over all four channels
    ev.ev_ready = 1'b1;
    edge_in = 4'b1111;
    step();
`ifdef EDGE_ARB_FIXED_PRIO_EN
    edge_in = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("fp_valid", int'(ev.ev_valid), 1);
      chk("fp_ch", int'(ev.ev_ch), 0);
    end
    edge_in = '0;
    repeat (8) step();
`else
    edge_in = '0;
    for (int k = 0; k < NCH; k++) begin
      step();
      chk("rr_valid", int'(ev.ev_valid), 1);
      chk("rr_ch", int'(ev.ev_ch), k);
    end
    step();
    chk("rr_done", int'(ev.ev_valid), 0);
`endif

    // Single pulse: two-cycle latency, one-cycle event
    edge_in = 4'b0100;
    step();
    edge_in = '0;
    chk("sp_lat_valid", int'(ev.ev_valid), 0);
    chk("sp_lat_pend", int'(pend_any), 1);
    step();
    chk("sp_valid", int'(ev.ev_valid), 1);
    chk("sp_ch", int'(ev.ev_ch), 2);
    step();
    chk("sp_done", int'(ev.ev_valid), 0);

    // Pulse and grant on ch0 in the same cycle
    edge_in = 4'b0001;
    step();
    step();
    edge_in = '0;
    chk("pg_valid", int'(ev.ev_valid), 1);
    chk("pg_ch", int'(ev.ev_ch), 0);
    chk("pg_pend", int'(pend_any), 1);
    step();
    chk("pg_valid2", int'(ev.ev_valid), 1);
    chk("pg_pend2", int'(pend_any), 0);
    step();
    chk("pg_done", int'(ev.ev_valid), 0);

    // Backpressure holds the presented event
    ev.ev_ready = 1'b0;
    edge_in = 4'b0010;
    step();
    step();
    edge_in = '0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", int'(ev.ev_valid), 1);
      chk("bp_ch", int'(ev.ev_ch), 1);
      step();
    end
    ev.ev_ready = 1'b1;
    step();
    chk("bp_next_valid", int'(ev.ev_valid), 1);
    chk("bp_next_ch", int'(ev.ev_ch), 1);
    chk("bp_next_pend", int'(pend_any), 0);
    step();
    chk("bp_done", int'(ev.ev_valid), 0);

    // Saturation on ch3 while ch0 occupies the slot
    ev.ev_ready = 1'b0;
    edge_in = 4'b0001;
    step();
    edge_in = 4'b1000;
    repeat (9) step();
    edge_in = '0;
    chk("sat_ovf", int'(ovf), 8);
    chk("sat_ch", int'(ev.ev_ch), 0);
    for (int i = 0; i < NCH; i++) acc[i] = 0;
    ev.ev_ready = 1'b1;
    repeat (9) step();
    chk("sat_drain3", acc[3], 7);
    chk("sat_drain0", acc[0], 1);
    chk("sat_empty", int'(ev.ev_valid), 0);
    chk("sat_ovf_hold", int'(ovf), 8);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("sat_ovf_clr", int'(ovf), 0);

    // Channel enable: dropped pulse, then skipped until re-enabled
    ev.ev_ready = 1'b0;
    ch_en = 4'b1011;
    edge_in = 4'b0100;
    step();
    edge_in = '0;
    step();
    chk("en_drop_pend", int'(pend_any), 0);
    chk("en_drop_valid", int'(ev.ev_valid), 0);
    ch_en = 4'b1111;
    edge_in = 4'b0001;
    step();
    edge_in = 4'b0100;
    step();
    step();
    ch_en = 4'b1011;
    edge_in = 4'b0010;
    step();
    edge_in = '0;
    chk("en_hold_ch", int'(ev.ev_ch), 0);
    ev.ev_ready = 1'b1;
    step();
    chk("en_skip_ch", int'(ev.ev_ch), 1);
    step();
    chk("en_skip_valid", int'(ev.ev_valid), 0);
    chk("en_skip_pend", int'(pend_any), 1);
    step();
    ch_en = 4'b1111;
    step();
    chk("en_re_valid", int'(ev.ev_valid), 1);
    chk("en_re_ch", int'(ev.ev_ch), 2);
    step();
    chk("en_re_ch2", int'(ev.ev_ch), 2);
    step();
    chk("en_re_done", int'(ev.ev_valid), 0);
    chk("en_re_pend", int'(pend_any), 0);

    // Asynchronous reset mid-traffic
    ev.ev_ready = 1'b0;
    edge_in = 4'b0100;
    step();
    edge_in = 4'b0010;
    repeat (3) step();
    edge_in = '0;
    chk("mr_pre_ch", int'(ev.ev_ch), 2);
    chk("mr_pre_pend", int'(pend_any), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_valid", int'(ev.ev_valid), 0);
    chk("mr_ch", int'(ev.ev_ch), 0);
    chk("mr_pend", int'(pend_any), 0);
    chk("mr_ovf", int'(ovf), 0);
    step();
    rst = 1'b0;
    ev.ev_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("mr_quiet", int'(ev.ev_valid), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
